// File: rtl/combo_ctrl_pkg.sv
// Shared definitions for the combination-lock controller: FSM state encoding,
// default parameter values and a small saturating-increment helper.
package combo_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_CHECK,
    S_OPEN,
    S_PROG,
    S_LOCKOUT
  } state_t;

  localparam int unsigned DEF_NDIG       = 3;
  localparam logic [23:0] DEF_CODE_INIT  = 24'h12_34_56;
  localparam int unsigned DEF_MAX_FAIL   = 3;
  localparam int unsigned DEF_LOCK_TICKS = 5000;
  localparam int unsigned DEF_IDLE_TICKS = 10000;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v, input logic [1:0] lim);
    return (v >= lim) ? lim : v + 2'd1;
  endfunction

endpackage

// File: rtl/combo_ctrl_tick_timer.sv
// Loadable down-counter shared by the entry timeout and the lockout period.
// o_done fires on the enabled cycle in which the loaded count runs out.
module tick_timer #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = i_en && !i_load && (r_cnt == W'(1));

endmodule

// File: rtl/combo_ctrl.sv
// Master FSM of the combination lock: digit entry and checking, failure
// lockout, entry timeout and reprogramming of the stored combination.
module combo_ctrl
  import combo_ctrl_pkg::*;
#(
  parameter int unsigned        NDIG       = DEF_NDIG,
  parameter logic [NDIG*8-1:0]  CODE_INIT  = DEF_CODE_INIT,
  parameter int unsigned        MAX_FAIL   = DEF_MAX_FAIL,
  parameter int unsigned        LOCK_TICKS = DEF_LOCK_TICKS,
  parameter int unsigned        IDLE_TICKS = DEF_IDLE_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cnten,
  input  logic       dirch,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic       prog,
  input  logic       lock,
  input  logic       doorCls,
  output logic       clrCount,
  output logic [1:0] idx,
  output logic       codeOk,
  output logic       lockout,
  output logic       blank,
  output logic [1:0] failCnt,
  output logic       progDone
);

  localparam int unsigned TMAX = (LOCK_TICKS > IDLE_TICKS) ? LOCK_TICKS : IDLE_TICKS;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [1:0]  LAST = 2'(NDIG - 1);
  localparam logic [1:0]  FMAX = 2'(MAX_FAIL);

  state_t              r_state;
  logic [1:0]          r_idx;
  logic                r_match;
  logic [1:0]          r_fail;
  logic [NDIG*8-1:0]   r_code;
  logic                r_clr, r_code_ok, r_lockout, r_blank, r_prog_done;

  logic [7:0]          w_bcd;
  logic [7:0]          w_bytes [NDIG];
  logic [NDIG*8-1:0]   w_code_wr;
  logic [1:0]          w_fail_nx;
  logic                w_tmr_load, w_tmr_en, w_tmr_done;
  logic [TW-1:0]       w_tmr_val;

  assign w_bcd     = {bcd1, bcd0};
  assign w_fail_nx = sat_inc2(r_fail, FMAX);

  // Entry 0 sits in the most significant byte of the stored code.
  for (genvar g = 0; g < NDIG; g++) begin : g_byte
    assign w_bytes[g] = r_code[(NDIG-1-g)*8 +: 8];
    assign w_code_wr[(NDIG-1-g)*8 +: 8] = (r_idx == 2'(g)) ? w_bcd : r_code[(NDIG-1-g)*8 +: 8];
  end

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_en   = 1'b0;
    w_tmr_val  = TW'(IDLE_TICKS);
    unique case (r_state)
      S_IDLE:    w_tmr_load = cnten;
      S_ENTER: begin
        w_tmr_en   = 1'b1;
        w_tmr_load = cnten || dirch;
      end
      S_CHECK: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = TW'(LOCK_TICKS);
      end
      S_LOCKOUT: w_tmr_en = 1'b1;
      default: ;
    endcase
  end

  tick_timer #(.W(TW)) u_timer (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_match     <= 1'b0;
      r_fail      <= '0;
      r_code      <= CODE_INIT;
      r_clr       <= 1'b0;
      r_code_ok   <= 1'b0;
      r_lockout   <= 1'b0;
      r_blank     <= 1'b0;
      r_prog_done <= 1'b0;
    end else begin
      r_clr       <= 1'b0;
      r_prog_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (cnten) begin
          r_state <= S_ENTER;
          r_idx   <= '0;
          r_match <= 1'b1;
        end
        S_ENTER: begin
          if (dirch) begin
            r_match <= r_match && (w_bcd == w_bytes[r_idx]);
            r_clr   <= 1'b1;
            if (r_idx == LAST) begin
              r_state <= S_CHECK;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end else if (w_tmr_done) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_clr   <= 1'b1;
          end
        end
        S_CHECK: begin
          if (r_match) begin
            r_state   <= S_OPEN;
            r_code_ok <= 1'b1;
            r_fail    <= '0;
          end else begin
            r_fail <= w_fail_nx;
            r_clr  <= 1'b1;
            if (w_fail_nx == FMAX) begin
              r_state   <= S_LOCKOUT;
              r_lockout <= 1'b1;
              r_blank   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_OPEN: begin
          if (lock && doorCls) begin
            r_state   <= S_IDLE;
            r_code_ok <= 1'b0;
            r_clr     <= 1'b1;
          end else if (prog) begin
            r_state <= S_PROG;
            r_idx   <= '0;
          end
        end
        S_PROG: if (dirch) begin
          r_code <= w_code_wr;
          r_clr  <= 1'b1;
          if (r_idx == LAST) begin
            r_state     <= S_OPEN;
            r_idx       <= '0;
            r_prog_done <= 1'b1;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        S_LOCKOUT: if (w_tmr_done) begin
          r_state   <= S_IDLE;
          r_lockout <= 1'b0;
          r_blank   <= 1'b0;
          r_fail    <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign clrCount = r_clr;
  assign idx      = r_idx;
  assign codeOk   = r_code_ok;
  assign lockout  = r_lockout;
  assign blank    = r_blank;
  assign failCnt  = r_fail;
  assign progDone = r_prog_done;

endmodule

// File: tb/tb_combo_ctrl.sv
// Self-checking bench for combo_ctrl: directed scenarios plus random input
// traffic, every cycle compared against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_combo_ctrl;

  localparam int NDIG = 3, MAX_FAIL = 3, LOCK_TICKS = 5000, IDLE_TICKS = 10000;

  logic       clk = 1'b0;
  logic       reset, cnten, dirch, prog, lock, doorCls;
  logic [3:0] bcd1, bcd0;
  logic       clrCount, codeOk, lockout, blank, progDone;
  logic [1:0] idx, failCnt;

  int n_checks = 0, n_errors = 0;
  int clr_seen = 0, done_seen = 0;

  // behavioural model: digit queues, timestamps-as-counters, flags
  logic [7:0] m_code [NDIG];
  logic [7:0] m_q[$], m_pq[$];
  bit m_ent, m_judge, m_open, m_prog, e_clr, e_done;
  int m_quiet, m_lock_left, m_fails;

  combo_ctrl #(
    .NDIG(NDIG), .CODE_INIT(24'h12_34_56), .MAX_FAIL(MAX_FAIL),
    .LOCK_TICKS(LOCK_TICKS), .IDLE_TICKS(IDLE_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .cnten(cnten), .dirch(dirch), .bcd1(bcd1), .bcd0(bcd0),
    .prog(prog), .lock(lock), .doorCls(doorCls), .clrCount(clrCount), .idx(idx),
    .codeOk(codeOk), .lockout(lockout), .blank(blank), .failCnt(failCnt), .progDone(progDone)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_code = '{8'h12, 8'h34, 8'h56};
    m_q.delete(); m_pq.delete();
    m_ent = 0; m_judge = 0; m_open = 0; m_prog = 0;
    m_quiet = 0; m_lock_left = 0; m_fails = 0; e_clr = 0; e_done = 0;
  endtask

  task automatic model_step(input bit rn, c, d, input logic [7:0] v, input bit p, lk, dc);
    bit ok;
    e_clr = 0; e_done = 0;
    if (!rn) begin model_reset(); return; end
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_judge) begin
      m_judge = 0;
      ok = 1;
      foreach (m_q[i]) if (m_q[i] != m_code[i]) ok = 0;
      m_q.delete();
      if (ok) begin
        m_open = 1; m_fails = 0;
      end else begin
        m_fails = (m_fails + 1 > MAX_FAIL) ? MAX_FAIL : m_fails + 1;
        e_clr = 1;
        if (m_fails == MAX_FAIL) m_lock_left = LOCK_TICKS;
      end
    end else if (m_ent) begin
      if (d) begin
        m_q.push_back(v); e_clr = 1; m_quiet = 0;
        if (m_q.size() == NDIG) begin m_ent = 0; m_judge = 1; end
      end else if (c) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == IDLE_TICKS) begin m_ent = 0; m_q.delete(); e_clr = 1; end
      end
    end else if (m_prog) begin
      if (d) begin
        m_pq.push_back(v); e_clr = 1;
        if (m_pq.size() == NDIG) begin
          foreach (m_code[i]) m_code[i] = m_pq[i];
          m_pq.delete(); m_prog = 0; e_done = 1;
        end
      end
    end else if (m_open) begin
      if (lk && dc) begin m_open = 0; e_clr = 1; end
      else if (p) begin m_prog = 1; m_pq.delete(); end
    end else if (c) begin
      m_ent = 1; m_quiet = 0; m_q.delete();
    end
  endtask

  function automatic logic [7:0] rnd_bcd();
    return {4'($urandom % 10), 4'($urandom % 10)};
  endfunction

  task automatic tick(input bit rn, c, d, input logic [7:0] v, input bit p, lk, dc);
    logic [8:0] act, expv;
    int ei;
    reset = rn; cnten = c; dirch = d; bcd1 = v[7:4]; bcd0 = v[3:0];
    prog = p; lock = lk; doorCls = dc;
    @(posedge clk);
    model_step(rn, c, d, v, p, lk, dc);
    #2;
    ei = m_ent ? m_q.size() : (m_prog ? m_pq.size() : 0);
    act  = {clrCount, idx, codeOk, lockout, blank, failCnt, progDone};
    expv = {e_clr, 2'(ei), m_open, m_lock_left > 0, m_lock_left > 0, 2'(m_fails), e_done};
    check("outs", 32'(act), 32'(expv));
    if (clrCount) clr_seen++;
    if (progDone) done_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1, 0, 0, rnd_bcd(), 0, 0, 1'($urandom % 2));
  endtask

  // A few count steps with random gaps, then the closing direction change.
  task automatic enter_digit(input logic [7:0] v, input bit sim);
    repeat (1 + $urandom % 3) begin
      tick(1, 1, 0, rnd_bcd(), 0, 0, 0);
      idle($urandom % 3);
    end
    tick(1, sim, 1, v, 0, 0, 0);
  endtask

  task automatic enter_code(input logic [7:0] a, b, c, input bit sim);
    enter_digit(a, sim); enter_digit(b, sim); enter_digit(c, sim);
  endtask

  task automatic close_door();
    tick(1, 0, 0, rnd_bcd(), 0, 1, 1);
  endtask

  initial begin
    int n, c0, d0;
    logic [7:0] pool [10];
    pool = '{8'h12, 8'h34, 8'h56, 8'h07, 8'h08, 8'h09, 8'h33, 8'h44, 8'h55, 8'h99};
    model_reset();
    repeat (3) tick(0, 0, 0, rnd_bcd(), 0, 0, 0);
    check("rst_outs", 32'({clrCount, idx, codeOk, lockout, blank, failCnt, progDone}), 0);

    tick(1, 0, 0, 8'h00, 1, 0, 0);
    check("prog_in_idle", 32'(codeOk), 0);

    c0 = clr_seen;
    enter_code(8'h12, 8'h34, 8'h56, 0);
    check("clr_entry", 32'(clr_seen - c0), 3);
    idle(1);
    check("open_ok", 32'(codeOk), 1);
    check("open_fail", 32'(failCnt), 0);
    close_door();
    check("closed", 32'(codeOk), 0);

    enter_code(8'h11, 8'h22, 8'h33, 0); idle(1);
    check("fail1", 32'(failCnt), 1); idle(2);
    enter_code(8'h12, 8'h34, 8'h57, 0); idle(1);
    check("fail2", 32'(failCnt), 2); idle(2);
    enter_code(8'h00, 8'h34, 8'h56, 0); idle(1);
    check("fail3", 32'(failCnt), 3);
    check("lock_blank", 32'({lockout, blank}), 32'h3);
    n = 1;
    for (int i = 0; i < LOCK_TICKS + 1000; i++) begin
      tick(1, 1'($urandom % 2), 1'($urandom % 2), rnd_bcd(), 0, 1, 1);
      if (!lockout) break;
      n++;
    end
    check("lock_len", 32'(n), LOCK_TICKS);
    check("lock_fail_clr", 32'(failCnt), 0);

    enter_code(8'h12, 8'h34, 8'h56, 0); idle(1);
    tick(1, 0, 0, rnd_bcd(), 1, 0, 0);
    d0 = done_seen;
    enter_code(8'h07, 8'h08, 8'h09, 0);
    check("prog_done", 32'(done_seen - d0), 1);
    check("prog_keeps_open", 32'(codeOk), 1);
    close_door();
    enter_code(8'h07, 8'h08, 8'h09, 0); idle(1);
    check("new_code_opens", 32'(codeOk), 1);
    close_door();
    enter_code(8'h12, 8'h34, 8'h56, 0); idle(1);
    check("old_code_fails", 32'({codeOk, failCnt}), 32'h1);

    enter_digit(8'h12, 0);
    n = 0;
    for (int i = 0; i < IDLE_TICKS + 100; i++) begin
      idle(1); n++;
      if (clrCount) break;
    end
    check("timeout_len", 32'(n), IDLE_TICKS);
    check("timeout_fail", 32'({failCnt, idx}), 32'h4);

    enter_code(8'h07, 8'h08, 8'h09, 0); idle(1);
    tick(1, 0, 0, rnd_bcd(), 1, 0, 0);
    enter_code(8'h33, 8'h44, 8'h55, 1);
    close_door();
    enter_code(8'h33, 8'h44, 8'h55, 1); idle(1);
    check("sim_capture", 32'(codeOk), 1);

    tick(1, 0, 0, rnd_bcd(), 1, 1, 1);
    check("lock_beats_prog", 32'(codeOk), 0);

    enter_code(8'h33, 8'h44, 8'h55, 0); idle(1);
    tick(1, 0, 0, rnd_bcd(), 1, 0, 0);
    enter_digit(8'h99, 0);
    tick(0, 0, 0, rnd_bcd(), 0, 0, 0);
    check("rst_mid_prog", 32'({clrCount, idx, codeOk, lockout, blank, failCnt, progDone}), 0);
    enter_code(8'h12, 8'h34, 8'h56, 0); idle(1);
    check("init_code_back", 32'(codeOk), 1);
    close_door();

    repeat (600)
      tick(1, ($urandom % 10) < 3, ($urandom % 100) < 15, pool[$urandom % 10],
           ($urandom % 100) < 5, ($urandom % 100) < 20, 1'($urandom % 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
